// File: rtl/microchip_tpsram_model.sv
// -----------------------------------------------------------------------------
// microchip_tpsram_model
// Parametrised two-port (1W/1R) micro-RAM behavioural model.
// Optional read-address (array) stage and read-data output register give a
// read latency of 0..2 cycles. The same-address read-during-write policy is
// selectable. A valid bit and a collision flag travel with each read.
//
// Ports:
//   CLK          clock, all state on posedge
//   Reset        synchronous, active-low; clears pipeline/output state, not the array
//   BLK_EN       block enable, gates W_EN and R_EN
//   W_EN/W_ADDR/W_DATA   write port; out-of-range addresses are ignored
//   R_EN/R_ADDR          read request; out-of-range addresses return 0
//   R_DATA_EN    output register enable (0 = hold)
//   R_DATA_SL_N  output register synchronous load of SD_VAL, active-low
//   R_DATA       read data
//   R_VALID      R_DATA carries the result of an accepted read
//   COLLISION    that read met a same-address write at its array-read moment
// -----------------------------------------------------------------------------
module microchip_tpsram_model #(
  parameter int               WIDTH      = 12,
  parameter int               DEPTH      = 64,
  parameter bit               R_ADDR_REG = 1'b1,
  parameter bit               R_DATA_REG = 1'b1,
  parameter bit               RDW_MODE   = 1'b0,
  parameter logic [WIDTH-1:0] SD_VAL     = '0,
  localparam int              ADDR_W     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              BLK_EN,
  input  logic              W_EN,
  input  logic [ADDR_W-1:0] W_ADDR,
  input  logic [WIDTH-1:0]  W_DATA,
  input  logic              R_EN,
  input  logic [ADDR_W-1:0] R_ADDR,
  input  logic              R_DATA_EN,
  input  logic              R_DATA_SL_N,
  output logic [WIDTH-1:0]  R_DATA,
  output logic              R_VALID,
  output logic              COLLISION
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of 2.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];

  logic             w_in_range_s;
  logic             r_in_range_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] arr_data_s;
  logic             arr_vld_s;
  logic             arr_coll_s;

  // Result leaving the (optional) array stage, feeding the output stage.
  logic [WIDTH-1:0] st_data_s;
  logic             st_vld_s;
  logic             st_coll_s;

  // Address decode and read-during-write resolution at the array-read moment.
  always_comb begin
    w_in_range_s = ({1'b0, W_ADDR} < DEPTH_C);
    r_in_range_s = ({1'b0, R_ADDR} < DEPTH_C);
    wr_en_s      = BLK_EN & W_EN & w_in_range_s;
    arr_vld_s    = BLK_EN & R_EN;
    arr_coll_s   = 1'b0;
    arr_data_s   = '0;
    if (r_in_range_s) begin
      arr_coll_s = arr_vld_s & wr_en_s & (W_ADDR == R_ADDR);
      // The write lands on the closing edge, so the array still holds the
      // old word; write-through mode forwards the incoming data instead.
      if (arr_coll_s && RDW_MODE) begin
        arr_data_s = W_DATA;
      end else begin
        arr_data_s = mem_r[R_ADDR];
      end
    end else begin
      arr_data_s = '0;
    end
  end

  // Array write port; writes are accepted regardless of Reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[W_ADDR] <= W_DATA;
    end
  end

  generate
    if (R_ADDR_REG) begin : g_addr_reg
      logic [WIDTH-1:0] s1_data_r;
      logic             s1_vld_r;
      logic             s1_coll_r;

      // Array stage: the read happens on the address capture edge.
      always_ff @(posedge CLK) begin
        if (!Reset) begin
          s1_data_r <= '0;
          s1_vld_r  <= 1'b0;
          s1_coll_r <= 1'b0;
        end else begin
          s1_vld_r  <= arr_vld_s;
          s1_coll_r <= arr_coll_s;
          // Data only moves with a real read so idle cycles keep the last word.
          if (arr_vld_s) begin
            s1_data_r <= arr_data_s;
          end
        end
      end

      assign st_data_s = s1_data_r;
      assign st_vld_s  = s1_vld_r;
      assign st_coll_s = s1_coll_r;
    end else begin : g_addr_comb
      assign st_data_s = arr_data_s;
      assign st_vld_s  = arr_vld_s;
      assign st_coll_s = arr_coll_s;
    end

    if (R_DATA_REG) begin : g_data_reg
      logic [WIDTH-1:0] out_data_r;
      logic             out_vld_r;
      logic             out_coll_r;

      // Output register: Reset, then sync load, then enable; no backpressure.
      always_ff @(posedge CLK) begin
        if (!Reset) begin
          out_data_r <= '0;
          out_vld_r  <= 1'b0;
          out_coll_r <= 1'b0;
        end else if (!R_DATA_SL_N) begin
          out_data_r <= SD_VAL;
          out_vld_r  <= 1'b0;
          out_coll_r <= 1'b0;
        end else if (R_DATA_EN) begin
          out_vld_r  <= st_vld_s;
          out_coll_r <= st_coll_s;
          if (st_vld_s) begin
            out_data_r <= st_data_s;
          end
        end
      end

      assign R_DATA    = out_data_r;
      assign R_VALID   = out_vld_r;
      assign COLLISION = out_coll_r;
    end else begin : g_data_comb
      // Output-register controls have no effect without the register.
      logic unused_ctrl_s;
      assign unused_ctrl_s = R_DATA_EN ^ R_DATA_SL_N;

      assign R_DATA    = st_data_s;
      assign R_VALID   = st_vld_s;
      assign COLLISION = st_coll_s;
    end
  endgenerate

endmodule
